xadc_sample_packetizer: RTL and testbench

Consumes the 16-bit current-monitor and voltage sample streams produced by the XADC sampling path and serialises each matched pair into a framed 8-bit AXI stream for the host link. Sits downstream of the per-channel async sample FIFOs, in the host-side clock domain. Provides the byte-stream framing and the sequence numbering the host uses for sample alignment and loss detection.

---
 rtl/axis_io_if.sv | 15 +
 rtl/xadc_sample_packetizer.sv | 147 ++++++++++++++
 tb/tb_xadc_sample_packetizer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_io_if.sv
// AXI-Stream bundle shared by the XADC sample sinks and the framed byte source.
// Width is set per instance; tlast is unused on the sample sinks.
interface axis_io #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
  modport Source (output tvalid, output tdata, output tlast, input tready);
  modport Sink   (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/xadc_sample_packetizer.sv
// Packs matched current/voltage samples into HDR,SEQ,CUR,VOL[,CSUM] byte frames.
// Define PACKETIZER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module xadc_sample_packetizer #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic  clk,
  input  logic  rst,
  axis_io.Sink   current_sample,
  axis_io.Sink   voltage_sample,
  axis_io.Source packet_stream
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SEQ   = 3'd2,
    CUR_H = 3'd3,
    CUR_L = 3'd4,
    VOL_H = 3'd5,
    VOL_L = 3'd6
`ifdef PACKETIZER_CHECKSUM_EN
    , CSUM = 3'd7
`endif
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  seq_r, seq_s;
  logic [15:0] cur_r, cur_s;
  logic [15:0] vol_r, vol_s;
  logic        tvalid_r;
  logic        tlast_r;
  logic [7:0]  tdata_r;
  logic        take_s;
  logic        hs_s;

`ifdef PACKETIZER_CHECKSUM_EN
  function automatic logic [7:0] frame_csum(input logic [7:0] seq,
                                            input logic [15:0] cur,
                                            input logic [15:0] vol);
    frame_csum = seq ^ cur[15:8] ^ cur[7:0] ^ vol[15:8] ^ vol[7:0];
  endfunction
`endif

  function automatic logic [7:0] frame_byte(input state_t st,
                                            input logic [7:0] seq,
                                            input logic [15:0] cur,
                                            input logic [15:0] vol);
    case (st)
      HDR:     frame_byte = HEADER_BYTE;
      SEQ:     frame_byte = seq;
      CUR_H:   frame_byte = cur[15:8];
      CUR_L:   frame_byte = cur[7:0];
      VOL_H:   frame_byte = vol[15:8];
      VOL_L:   frame_byte = vol[7:0];
`ifdef PACKETIZER_CHECKSUM_EN
      CSUM:    frame_byte = frame_csum(seq, cur, vol);
`endif
      default: frame_byte = 8'h00;
    endcase
  endfunction

  function automatic logic is_last(input state_t st);
`ifdef PACKETIZER_CHECKSUM_EN
    is_last = (st == CSUM);
`else
    is_last = (st == VOL_L);
`endif
  endfunction

  // Both samples are taken in the same cycle, never one alone.
  assign take_s = !rst && (state_r == IDLE) &&
                  current_sample.tvalid && voltage_sample.tvalid;
  assign hs_s   = tvalid_r && packet_stream.tready;

  assign current_sample.tready = take_s;
  assign voltage_sample.tready = take_s;
  assign packet_stream.tvalid  = tvalid_r;
  assign packet_stream.tdata   = tdata_r;
  assign packet_stream.tlast   = tlast_r;

  // Next-state, sample capture and sequence update.
  always_comb begin
    state_s = state_r;
    seq_s   = seq_r;
    cur_s   = cur_r;
    vol_s   = vol_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          cur_s   = current_sample.tdata;
          vol_s   = voltage_sample.tdata;
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR:   if (hs_s) state_s = SEQ;   else state_s = HDR;
      SEQ:   if (hs_s) state_s = CUR_H; else state_s = SEQ;
      CUR_H: if (hs_s) state_s = CUR_L; else state_s = CUR_H;
      CUR_L: if (hs_s) state_s = VOL_H; else state_s = CUR_L;
      VOL_H: if (hs_s) state_s = VOL_L; else state_s = VOL_H;
`ifdef PACKETIZER_CHECKSUM_EN
      VOL_L: if (hs_s) state_s = CSUM;  else state_s = VOL_L;
      CSUM: begin
        if (hs_s) begin
          seq_s   = seq_r + 8'd1;
          state_s = IDLE;
        end else begin
          state_s = CSUM;
        end
      end
`else
      VOL_L: begin
        if (hs_s) begin
          seq_s   = seq_r + 8'd1;
          state_s = IDLE;
        end else begin
          state_s = VOL_L;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Output bytes are registered from the next state so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      seq_r    <= 8'd0;
      cur_r    <= 16'd0;
      vol_r    <= 16'd0;
      tvalid_r <= 1'b0;
      tdata_r  <= 8'h00;
      tlast_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      seq_r    <= seq_s;
      cur_r    <= cur_s;
      vol_r    <= vol_s;
      tvalid_r <= (state_s != IDLE);
      tdata_r  <= frame_byte(state_s, seq_s, cur_s, vol_s);
      tlast_r  <= is_last(state_s);
    end
  end

endmodule

// File: tb/tb_xadc_sample_packetizer.sv
// Scoreboard bench for xadc_sample_packetizer: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every output handshake.
module tb_xadc_sample_packetizer;

`ifdef PACKETIZER_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_io #(.DATA_W(16)) cur_if ();
  axis_io #(.DATA_W(16)) vol_if ();
  axis_io #(.DATA_W(8))  pkt_if ();

  xadc_sample_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .current_sample (cur_if),
    .voltage_sample (vol_if),
    .packet_stream  (pkt_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int captures = 0;
  int pulses = 0;
  logic [7:0] seq_model = 8'd0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  // monitor state
  int   idx = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;
  bit   b2b_on = 0;
  bit   have_hdr = 0;
  int   last_hdr = 0;
  int   gap = 0;
  int   b2b_checks = 0;
  bit   rand_bp = 0;
  logic [7:0] last_seq_byte = 8'h00;
  bit   seq_seen = 0;
  bit   wrap_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b, input logic l);
    exp_q.push_back({l, b});
  endfunction

  function automatic void push_frame(input logic [15:0] c, input logic [15:0] v);
    logic [7:0] cs;
    cs = seq_model ^ c[15:8] ^ c[7:0] ^ v[15:8] ^ v[7:0];
    push_byte(8'hA5, 1'b0);
    push_byte(seq_model, 1'b0);
    push_byte(c[15:8], 1'b0);
    push_byte(c[7:0], 1'b0);
    push_byte(v[15:8], 1'b0);
`ifdef PACKETIZER_CHECKSUM_EN
    push_byte(v[7:0], 1'b0);
    push_byte(cs, 1'b1);
`else
    push_byte(v[7:0], 1'b1);
`endif
    seq_model = seq_model + 8'd1;
  endfunction

  // Hand-computed frame for current 1234 / voltage ABCD at SEQ 00.
  function automatic void push_directed_1234_abcd();
    push_byte(8'hA5, 1'b0);
    push_byte(8'h00, 1'b0);
    push_byte(8'h12, 1'b0);
    push_byte(8'h34, 1'b0);
    push_byte(8'hAB, 1'b0);
`ifdef PACKETIZER_CHECKSUM_EN
    push_byte(8'hCD, 1'b0);
    push_byte(8'h40, 1'b1);
`else
    push_byte(8'hCD, 1'b1);
`endif
    seq_model = seq_model + 8'd1;
  endfunction

  task automatic send_pair(input logic [15:0] c, input logic [15:0] v, input bit use_model);
    bit took;
    took = 0;
    cur_if.tdata  = c;
    vol_if.tdata  = v;
    cur_if.tvalid = 1'b1;
    vol_if.tvalid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cur_if.tready && vol_if.tready) begin
        took = 1;
        break;
      end
    end
    if (took) begin
      if (use_model) push_frame(c, v);
      captures++;
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL capture_timeout: got no sink tready, required a capture");
    end
    cur_if.tvalid = 1'b0;
    vol_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      pkt_if.tready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      idx = 0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", {31'd0, pkt_if.tvalid}, 32'd1);
        check("stall_tdata", {24'd0, pkt_if.tdata}, {24'd0, prev_data});
        check("stall_tlast", {31'd0, pkt_if.tlast}, {31'd0, prev_last});
      end
      if (b2b_on && !pkt_if.tvalid) gap++;
      if (pkt_if.tvalid && pkt_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, pkt_if.tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte_tdata", {24'd0, pkt_if.tdata}, {24'd0, e[7:0]});
          check("byte_tlast", {31'd0, pkt_if.tlast}, {31'd0, e[8]});
        end
        if (idx == 0 && b2b_on) begin
          if (have_hdr) begin
            check("b2b_period", cyc - last_hdr, FRAME_LEN + 1);
            check("b2b_idle_gap", gap, 1);
            b2b_checks++;
          end
          last_hdr = cyc;
          have_hdr = 1;
          gap = 0;
        end
        if (idx == 1) begin
          if (seq_seen && last_seq_byte == 8'hFF && pkt_if.tdata == 8'h00) wrap_seen = 1;
          last_seq_byte = pkt_if.tdata;
          seq_seen = 1;
        end
        idx = (idx == FRAME_LEN - 1) ? 0 : idx + 1;
      end
      prev_stall = pkt_if.tvalid && !pkt_if.tready;
      prev_data  = pkt_if.tdata;
      prev_last  = pkt_if.tlast;
    end
    if (cur_if.tready) pulses++;
    if (cur_if.tready || vol_if.tready)
      check("sink_tready_pair", {31'd0, cur_if.tready}, {31'd0, vol_if.tready});
  end

  initial begin
    cur_if.tvalid = 1'b1;
    vol_if.tvalid = 1'b1;
    cur_if.tdata  = 16'hDEAD;
    vol_if.tdata  = 16'hBEEF;
    cur_if.tlast  = 1'b0;
    vol_if.tlast  = 1'b0;
    pkt_if.tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tvalid", {31'd0, pkt_if.tvalid}, 32'd0);
    check("reset_tdata", {24'd0, pkt_if.tdata}, 32'd0);
    check("reset_tlast", {31'd0, pkt_if.tlast}, 32'd0);
    check("reset_cur_tready", {31'd0, cur_if.tready}, 32'd0);
    check("reset_vol_tready", {31'd0, vol_if.tready}, 32'd0);
    @(posedge clk);
    #1;
    cur_if.tvalid = 1'b0;
    vol_if.tvalid = 1'b0;
    rst = 1'b0;

    // single directed frame
    push_directed_1234_abcd();
    send_pair(16'h1234, 16'hABCD, 0);
    drain();

    // lone current valid is held, not consumed
    cur_if.tvalid = 1'b1;
    cur_if.tdata  = 16'h0F0F;
    vol_if.tvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("lone_cur_tready", {31'd0, cur_if.tready}, 32'd0);
      check("lone_pkt_tvalid", {31'd0, pkt_if.tvalid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send_pair(16'h0F0F, 16'h0001, 1);
    drain();

    // reset while CUR_L is stalled
    send_pair(16'h5566, 16'h7788, 1);
    repeat (3) @(posedge clk);
    #1;
    pkt_if.tready = 1'b0;
    @(negedge clk);
    check("stalled_cur_l", {24'd0, pkt_if.tdata}, 32'h66);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    seq_model = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_tvalid", {31'd0, pkt_if.tvalid}, 32'd0);
    check("post_reset_tlast", {31'd0, pkt_if.tlast}, 32'd0);
    @(posedge clk);
    #1;
    pkt_if.tready = 1'b1;
    push_directed_1234_abcd();
    send_pair(16'h1234, 16'hABCD, 0);
    drain();

    // back-to-back frames, sinks always valid
    have_hdr = 0;
    gap = 0;
    b2b_on = 1;
    for (int i = 0; i < 6; i++)
      send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i * 3), 1);
    drain();
    b2b_on = 0;
    check("b2b_check_count", b2b_checks, 5);

    // random backpressure over 300 frames
    rand_bp = 1;
    for (int i = 0; i < 300; i++)
      send_pair(16'(i * 16'h0125 + 16'h0100), 16'(i * 16'h3011) ^ 16'h5A5A, 1);
    drain();
    rand_bp = 0;
    @(posedge clk);
    #1;
    pkt_if.tready = 1'b1;
    repeat (3) @(posedge clk);

    check("seq_wrap_seen", {31'd0, wrap_seen}, 32'd1);
    check("sink_pulses_vs_captures", pulses, captures);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
